// File: rtl/mem_bank_pkg.sv
// Shared types and constants for the mem_bank initiator and its response buffer.
package mem_bank_pkg;

  // Default geometry of the attached mem_bank; the initiator's parameters default to these.
  localparam int PkgAddrWidth = 9;
  localparam int PkgDataSize  = 2;
  localparam int DataBytes    = 1 << PkgDataSize;
  localparam int DataWidth    = DataBytes * 8;

  // One access as presented to mem_bank.
  typedef struct packed {
    logic                 we;
    logic [PkgAddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [DataBytes-1:0] wstrb;
  } mem_req_t;

  // One response as returned on the response stream.
  typedef struct packed {
    logic                 we;
    logic [DataWidth-1:0] rdata;
  } mem_rsp_t;

  // Increment an index modulo depth; depth need not be a power of two.
  function automatic int unsigned wrap_incr(input int unsigned idx, input int unsigned depth);
    return (idx + 1 >= depth) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_bank_rsp_buf.sv
// Small synchronous FIFO of mem_rsp_t. Head is read straight from storage so
// the response outputs are register-driven and hold while stalled.
module mem_bank_rsp_buf
  import mem_bank_pkg::*;
#(
  parameter int Depth = 4,
  parameter int CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            arst_ni,
  input  logic            push_i,
  input  mem_rsp_t        push_data_i,
  input  logic            pop_i,
  output mem_rsp_t        head_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  mem_rsp_t        store_q [Depth];
  mem_rsp_t        store_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Next-state: write at the tail, advance the head on pop, track occupancy.
  always_comb begin
    store_d  = store_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      store_d[wr_ptr_q] = push_data_i;
      wr_ptr_d          = PtrW'(wrap_incr(32'(wr_ptr_q), Depth));
    end
    if (pop_i) begin
      rd_ptr_d = PtrW'(wrap_incr(32'(rd_ptr_q), Depth));
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared so the response outputs read zero after reset.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        store_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      store_q  <= store_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = store_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mem_bank_initiator.sv
// Turns a valid/ready request stream into single-cycle mem_bank accesses and
// returns each access's read data, in order, on a valid/ready response stream.
module mem_bank_initiator
  import mem_bank_pkg::*;
#(
  parameter int AddrWidth = PkgAddrWidth,
  parameter int DataSize  = PkgDataSize,
  parameter int RspDepth  = 4
) (
  input  logic                        clk_i,
  input  logic                        arst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_we_i,
  input  logic [AddrWidth-1:0]        req_addr_i,
  input  logic [(8<<DataSize)-1:0]    req_wdata_i,
  input  logic [(1<<DataSize)-1:0]    req_wstrb_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic                        rsp_we_o,
  output logic [(8<<DataSize)-1:0]    rsp_rdata_o,
  output logic                        mem_cs_o,
  output logic [AddrWidth-1:0]        mem_addr_o,
  output logic [(8<<DataSize)-1:0]    mem_wdata_o,
  output logic [(1<<DataSize)-1:0]    mem_wstrb_o,
  input  logic [(8<<DataSize)-1:0]    mem_rdata_i
);

  localparam int CntW = $clog2(RspDepth + 1);

  mem_req_t        drive_d, drive_q;
  logic            mem_cs_d, mem_cs_q;
  logic            accept;
  logic            rsp_pop;
  logic            rsp_empty;
  logic [CntW-1:0] rsp_count;
  logic [CntW:0]   used;
  mem_rsp_t        rsp_push_data;
  mem_rsp_t        rsp_head;

  // Credits: buffered responses plus the one access that may be in flight.
  // Built only from registers, so neither rsp_ready_i nor req_valid_i reaches req_ready_o.
  assign used        = {1'b0, rsp_count} + {{CntW{1'b0}}, mem_cs_q};
  assign req_ready_o = (used < (CntW + 1)'(RspDepth));
  assign accept      = req_valid_i & req_ready_o;

  // Drive stage: capture an accepted request; otherwise drop cs and hold the rest.
  always_comb begin
    drive_d  = drive_q;
    mem_cs_d = 1'b0;
    if (accept) begin
      mem_cs_d      = 1'b1;
      drive_d.we    = req_we_i;
      drive_d.addr  = req_addr_i;
      drive_d.wdata = req_wdata_i;
      drive_d.wstrb = req_we_i ? req_wstrb_i : '0;
    end
  end

  // Drive stage registers.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      drive_q  <= '0;
      mem_cs_q <= 1'b0;
    end else begin
      drive_q  <= drive_d;
      mem_cs_q <= mem_cs_d;
    end
  end

  assign mem_cs_o    = mem_cs_q;
  assign mem_addr_o  = drive_q.addr;
  assign mem_wdata_o = drive_q.wdata;
  assign mem_wstrb_o = drive_q.wstrb;

  // The word on mem_rdata_i during the access cycle is the pre-write value,
  // so writes return the old word too.
  assign rsp_push_data.we    = drive_q.we;
  assign rsp_push_data.rdata = mem_rdata_i;

  assign rsp_valid_o = ~rsp_empty;
  assign rsp_pop     = rsp_valid_o & rsp_ready_i;
  assign rsp_we_o    = rsp_head.we;
  assign rsp_rdata_o = rsp_head.rdata;

  mem_bank_rsp_buf #(
    .Depth (RspDepth),
    .CntW  (CntW)
  ) u_rsp_buf (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .push_i      (mem_cs_q),
    .push_data_i (rsp_push_data),
    .pop_i       (rsp_pop),
    .head_o      (rsp_head),
    .empty_o     (rsp_empty),
    .count_o     (rsp_count)
  );

endmodule

// File: tb/tb_mem_bank_initiator.sv
// Bench for mem_bank_initiator: behavioural mem_bank device, byte-array reference
// model and expected-response queue built at request acceptance time.
module tb_mem_bank_initiator;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        req_valid, req_ready, req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [31:0] rsp_rdata;
  logic        mem_cs;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  logic [7:0]  model_mem [512];
  logic [31:0] dev_mem [128];
  logic        dev_clear;
  int          n_acc = 0;
  int          hold_viol = 0;
  int          ready_drop = 0;
  bit          track_ready = 0;
  bit          stall_pending = 0;
  logic [32:0] stall_val;

  always #5 clk = ~clk;

  mem_bank_initiator dut (
    .clk_i       (clk),
    .arst_ni     (arst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_wstrb_i (req_wstrb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_we_o    (rsp_we),
    .rsp_rdata_o (rsp_rdata),
    .mem_cs_o    (mem_cs),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_wstrb_o (mem_wstrb),
    .mem_rdata_i (mem_rdata)
  );

  // mem_bank device: combinational read of the addressed word, byte-strobed write on cs.
  assign mem_rdata = dev_mem[mem_addr[8:2]];
  always @(posedge clk) begin
    if (dev_clear) begin
      for (int i = 0; i < 128; i++) dev_mem[i] <= '0;
    end else if (mem_cs) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) dev_mem[mem_addr[8:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  // Reference: an accepted request yields the word as it was, then applies strobed bytes.
  task automatic model_accept();
    int base;
    logic [31:0] old;
    base = int'({req_addr[8:2], 2'b00});
    for (int b = 0; b < 4; b++) old[b*8 +: 8] = model_mem[base + b];
    exp_q.push_back({req_we, old});
    if (req_we)
      for (int b = 0; b < 4; b++)
        if (req_wstrb[b]) model_mem[base + b] = req_wdata[b*8 +: 8];
    n_acc++;
  endtask

  // One clock: observe handshakes at the falling edge, then advance past the rising edge.
  task automatic step();
    @(negedge clk);
    if (req_valid && req_ready) model_accept();
    if (rsp_valid && rsp_ready) obs_q.push_back({rsp_we, rsp_rdata});
    if (stall_pending && (!rsp_valid || {rsp_we, rsp_rdata} !== stall_val)) hold_viol++;
    stall_pending = rsp_valid && !rsp_ready;
    stall_val     = {rsp_we, rsp_rdata};
    if (track_ready && !req_ready) ready_drop++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (obs_q.size() >= exp_q.size() && !mem_cs && !rsp_valid) break;
      step();
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0; dev_clear = 1'b1; rsp_ready = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rsp_valid, rsp_we, rsp_rdata, mem_cs, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      bad++;
      $display("FAIL reset_state: got valid=%b we=%b rdata=%h cs=%b addr=%h wdata=%h wstrb=%h want all zero",
               rsp_valid, rsp_we, rsp_rdata, mem_cs, mem_addr, mem_wdata, mem_wstrb);
    end
    @(negedge clk); arst_n = 1'b1; dev_clear = 1'b0;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    // Mid-stream: two responses buffered plus one in flight, then reset.
    for (int i = 0; i < 3; i++) begin
      set_req(1'b0, 9'(9'h010 + 4 * i), 32'h0, 4'h0);
      step();
    end
    total++;
    if ({rsp_valid, mem_cs} !== 2'b11) begin
      bad++; $display("FAIL reset_prefill: got valid=%b cs=%b want 1 1", rsp_valid, mem_cs);
    end
    arst_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, mem_cs} !== 2'b00) begin
      bad++; $display("FAIL reset_async: got valid=%b cs=%b want 0 0", rsp_valid, mem_cs);
    end
    req_valid = 1'b0;
    exp_q.delete(); obs_q.delete(); stall_pending = 0;
    @(posedge clk);
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      bad++; $display("FAIL reset_release: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
    $display("reset: checked");
  endtask

  task automatic test_basic();
    rsp_ready = 1'b1;
    set_req(1'b1, 9'h000, 32'h12345678, 4'hF);
    step();
    total++;
    if ({mem_cs, mem_wstrb, mem_wdata, rsp_valid} !== {1'b1, 4'hF, 32'h12345678, 1'b0}) begin
      bad++; $display("FAIL basic_drive: got cs=%b wstrb=%h wdata=%h valid=%b want 1 f 12345678 0",
                      mem_cs, mem_wstrb, mem_wdata, rsp_valid);
    end
    set_req(1'b0, 9'h000, 32'h0, 4'h0);
    step();
    total++;
    if ({rsp_valid, rsp_we, rsp_rdata} !== {2'b11, 32'h0}) begin
      bad++; $display("FAIL basic_wr_rsp: got valid=%b we=%b rdata=%h want 1 1 00000000",
                      rsp_valid, rsp_we, rsp_rdata);
    end
    req_valid = 1'b0;
    step();
    total++;
    if ({rsp_valid, rsp_we, rsp_rdata} !== {2'b10, 32'h12345678}) begin
      bad++; $display("FAIL basic_rd_rsp: got valid=%b we=%b rdata=%h want 1 0 12345678",
                      rsp_valid, rsp_we, rsp_rdata);
    end
    drain();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL basic_rsp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
    $display("basic: write+read done");
  endtask

  task automatic test_strobe();
    rsp_ready = 1'b1;
    set_req(1'b1, 9'h000, 32'h87654321, 4'hF);    step();
    set_req(1'b1, 9'h000, 32'h98765432, 4'b0011); step();
    set_req(1'b0, 9'h000, 32'h0, 4'h0);           step();
    drain();
    total++;
    if (obs_q.size() != 3 || obs_q[obs_q.size()-1] !== {1'b0, 32'h87655432}) begin
      bad++; $display("FAIL strobe_merge: got n=%0d last=%h want n=3 last=087655432",
                      obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 33'h0);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL strobe_rsp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
    $display("strobe: partial write done");
  endtask

  task automatic test_read_strobe();
    rsp_ready = 1'b1;
    set_req(1'b0, 9'h000, 32'hFFFFFFFF, 4'hF);
    step();
    total++;
    if ({mem_cs, mem_wstrb} !== 5'b1_0000) begin
      bad++; $display("FAIL read_strobe_drive: got cs=%b wstrb=%h want 1 0", mem_cs, mem_wstrb);
    end
    set_req(1'b0, 9'h000, 32'h0, 4'h0);
    step();
    drain();
    total++;
    if (obs_q.size() != 2 || obs_q[1] !== {1'b0, 32'h87655432}) begin
      bad++; $display("FAIL read_strobe_data: got n=%0d last=%h want n=2 last=087655432",
                      obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 33'h0);
    end
    obs_q.delete(); exp_q.delete();
    $display("read_strobe: read with strobes done");
  endtask

  task automatic test_backpressure();
    int start, idx, obs_at5;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, 9'(4 * i), 32'hA0000000 + 32'(i), 4'hF);
      step();
    end
    drain();
    obs_q.delete(); exp_q.delete();
    rsp_ready = 1'b0;
    start = n_acc; idx = 0; obs_at5 = -1;
    for (int c = 0; c < 8; c++) begin
      set_req(1'b0, 9'(4 * idx), 32'h0, 4'h0);
      step();
      idx = n_acc - start;
    end
    total++;
    if (idx != 4 || req_ready !== 1'b0) begin
      bad++; $display("FAIL bp_stall: got accepted=%0d ready=%b want 4 0", idx, req_ready);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 30 && idx < 6; c++) begin
      set_req(1'b0, 9'(4 * idx), 32'h0, 4'h0);
      step();
      idx = n_acc - start;
      if (idx == 5 && obs_at5 < 0) obs_at5 = obs_q.size();
    end
    drain();
    total++;
    if (idx != 6 || obs_at5 < 1) begin
      bad++; $display("FAIL bp_resume: got accepted=%0d rsp_before_5th=%0d want 6 >=1", idx, obs_at5);
    end
    total++;
    if (obs_q.size() != 6) begin
      bad++; $display("FAIL bp_count: got %0d want 6", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 6; i++) begin
      total++;
      if (obs_q[i] !== {1'b0, 32'hA0000000 + 32'(i)}) begin
        bad++; $display("FAIL bp_order[%0d]: got %h want %h", i, obs_q[i], {1'b0, 32'hA0000000 + 32'(i)});
      end
    end
    obs_q.delete(); exp_q.delete();
    $display("backpressure: 6 reads through 4 credits done");
  endtask

  task automatic test_stress();
    int start, mism;
    start = n_acc; hold_viol = 0; mism = 0;
    for (int c = 0; c < 40000 && (n_acc - start) < 10000; c++) begin
      req_valid = ($urandom_range(0, 4) != 0);
      req_we    = 1'($urandom);
      req_addr  = 9'($urandom);
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
      rsp_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    drain();
    total++;
    if (n_acc - start != 10000) begin
      bad++; $display("FAIL stress_accepts: got %0d want 10000", n_acc - start);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL stress_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; mism++;
        if (mism <= 10) $display("FAIL stress_rsp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (hold_viol != 0) begin
      bad++; $display("FAIL stress_hold: got %0d violations want 0", hold_viol);
    end
    obs_q.delete(); exp_q.delete();
    // Full-rate phase: with responses always taken, requests must never be throttled.
    rsp_ready = 1'b1; track_ready = 1; ready_drop = 0;
    for (int c = 0; c < 300; c++) begin
      set_req(1'($urandom), 9'($urandom), $urandom, 4'($urandom));
      step();
    end
    track_ready = 0;
    drain();
    total++;
    if (ready_drop != 0) begin
      bad++; $display("FAIL stress_full_rate: got %0d ready drops want 0", ready_drop);
    end
    total++;
    if (obs_q.size() != 300 || exp_q.size() != 300) begin
      bad++; $display("FAIL stress_rate_count: got %0d/%0d want 300", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL stress_rate_rsp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
    $display("stress: %0d random ops done", n_acc - start);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) model_mem[i] = '0;
    test_reset();
    test_basic();
    test_strobe();
    test_read_strobe();
    test_backpressure();
    test_stress();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
